// File: rtl/demux_1to4_reg_if.sv
// Bus bundle for demux_1to4_reg: one input channel and four registered output channels.
// The master drives the source and sink-ready sides; the slave is the demux itself.
interface demux_1to4_reg_if #(
   parameter int WIDTH = 24
);
   logic [WIDTH-1:0] in_data;
   logic [2:0]       Selector;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic [WIDTH-1:0] out1_data;
   logic [WIDTH-1:0] out2_data;
   logic [WIDTH-1:0] out3_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [15:0]      accept_count;

   modport master (
      output in_data, Selector, in_valid, out_ready,
      input  in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, accept_count
   );

   modport slave (
      input  in_data, Selector, in_valid, out_ready,
      output in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, accept_count
   );
endinterface

// File: rtl/demux_1to4_reg.sv
// 1-to-4 demultiplexer with a one-entry holding register per destination,
// unicast or all-or-nothing broadcast, and a wrapping accepted-transfer counter.
module demux_1to4_reg #(
   parameter int WIDTH = 24
) (
   input logic              Clock,
   input logic              Reset,
   demux_1to4_reg_if.slave  bus
);
   logic [WIDTH-1:0] data_reg [4];
   logic [3:0]       valid_reg;
   logic [15:0]      count_reg;
   logic [3:0]       free;
   logic [3:0]       load;
   logic             ready_next;
   logic             xfer;

   // A slot can take new data if it is empty or is being consumed this cycle.
   assign free = ~valid_reg | bus.out_ready;

   always_comb begin
      ready_next = 1'b0;
      if (!Reset) begin
         if (bus.Selector[2])
            ready_next = &free;
         else
            ready_next = free[bus.Selector[1:0]];
      end
   end

   assign bus.in_ready = ready_next;
   assign xfer         = bus.in_valid & ready_next;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         assign load[gi] = xfer & (bus.Selector[2] | (bus.Selector[1:0] == 2'(gi)));

         // Load beats drain, so a slot can be refilled in the cycle it empties.
         always_ff @(posedge Clock) begin
            if (Reset) begin
               data_reg[gi]  <= '0;
               valid_reg[gi] <= 1'b0;
            end else if (load[gi]) begin
               data_reg[gi]  <= bus.in_data;
               valid_reg[gi] <= 1'b1;
            end else if (bus.out_ready[gi]) begin
               valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge Clock) begin
      if (Reset)
         count_reg <= '0;
      else if (xfer)
         count_reg <= count_reg + 16'd1;
   end

   assign bus.out0_data    = data_reg[0];
   assign bus.out1_data    = data_reg[1];
   assign bus.out2_data    = data_reg[2];
   assign bus.out3_data    = data_reg[3];
   assign bus.out_valid    = valid_reg;
   assign bus.accept_count = count_reg;
endmodule
